// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and constants for the MIPS fetch unit
//
// Purpose : FSM state encoding, main opcode constants and the default
//           reset PC used by unidad_busqueda and its sub-module.
// Ports   : none (package).
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/calc_sig_pc.sv
// rtl/calc_sig_pc.sv - combinational next-PC selection (sequential / beq / j)
//
// Purpose : picks the next program counter from the decoder branch controls
//           and the ALU zero flag. Jump has priority over a taken beq.
// Ports   : pc_plus4    in  ADDR_W  current pc + 4
//           instr       in  26      instruction index/immediate field instr[25:0]
//           SaltoCond   in  1       conditional-branch control
//           Saltoincond in  1       unconditional-jump control
//           Zero        in  1       ALU zero flag
//           next_pc     out ADDR_W  selected next pc
module calc_sig_pc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [25:0]       instr,
  input  logic              SaltoCond,
  input  logic              Saltoincond,
  input  logic              Zero,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] branch_target;

  // j keeps the 256 MB region of pc+4 and replaces the low 28 bits.
  assign jump_target   = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
  // Sign-extended word offset; the add wraps modulo 2^ADDR_W.
  assign branch_offset = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;

  always_comb begin
    next_pc = pc_plus4;
    if (Saltoincond) begin
      next_pc = jump_target;
    end else if (SaltoCond && Zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/unidad_busqueda.sv
// rtl/unidad_busqueda.sv - instruction fetch and PC sequencing unit
//
// Purpose : fetches instructions over a req/ack handshake, holds them for the
//           datapath while instr_valid is high, and advances the pc when the
//           datapath signals exec_done.
// Config  : FETCH_PERF_EN adds the instr_retired counter output.
// Ports   : clk, reset_n (sync, active low), en (run enable)
//           imem_req/imem_addr/imem_ack/imem_data  instruction memory port
//           instr, opcode, instr_valid             captured instruction
//           exec_done                              datapath completion
//           SaltoCond, Saltoincond, Zero           branch controls / ALU flag
//           pc, pc_plus4                           program counter outputs
//           instr_retired (FETCH_PERF_EN only)     retired instruction count
module unidad_busqueda
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              SaltoCond,
  input  logic              Saltoincond,
  input  logic              Zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       instr_retired
`endif
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] next_pc;
  logic              retire;

  // Outputs decode straight from the registered state (Moore).
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == ISSUE);
  assign imem_addr   = pc;
  assign opcode      = instr[31:26];
  assign pc_plus4    = pc + ADDR_W'(4);
  assign retire      = (state == ISSUE) && exec_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en) state_n = FETCH;
      // en is not looked at here: an issued request always completes.
      FETCH:   if (imem_ack) state_n = ISSUE;
      ISSUE:   if (exec_done) state_n = en ? FETCH : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      if ((state == FETCH) && imem_ack) begin
        instr <= imem_data;
      end
      if (retire) begin
        pc <= next_pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_retired <= 32'h0;
    end else if (retire) begin
      instr_retired <= instr_retired + 32'd1;
    end
  end
`endif

  calc_sig_pc #(
    .ADDR_W(ADDR_W)
  ) u_calc_sig_pc (
    .pc_plus4   (pc_plus4),
    .instr      (instr[25:0]),
    .SaltoCond  (SaltoCond),
    .Saltoincond(Saltoincond),
    .Zero       (Zero),
    .next_pc    (next_pc)
  );

endmodule

// File: tb/tb_unidad_busqueda.sv
// tb/tb_unidad_busqueda.sv - self-checking bench for unidad_busqueda
module tb_unidad_busqueda;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        exec_done = 1'b0;
  logic        SaltoCond = 1'b0;
  logic        Saltoincond = 1'b0;
  logic        Zero = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] instr_retired;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_pc;
  int          r_wait, r_req;
  logic [31:0] r_addr;
  bit          r_stable, r_tmo;

  unidad_busqueda dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .exec_done(exec_done),
    .SaltoCond(SaltoCond), .Saltoincond(Saltoincond), .Zero(Zero),
    .pc(pc), .pc_plus4(pc_plus4)
`ifdef FETCH_PERF_EN
    , .instr_retired(instr_retired)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // Reference next-PC rule, written from the architectural definition.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input bit sc, input bit sj, input bit z);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    off = $signed(w[15:0]);
    if (sj) return (seq & 32'hF000_0000) | (w[25:0] * 32'd4);
    if (sc && z) return seq + 32'(off * 4);
    return seq;
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] idx);
    return {OP_J, idx};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [15:0] imm);
    return {OP_BEQ, 5'd1, 5'd2, imm};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; en = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    SaltoCond = 1'b0; Saltoincond = 1'b0; Zero = 1'b0;
    step; step;
    reset_n = 1'b1;
    m_pc = 32'h0;
  endtask

  // Serve one fetch: ack after 'delay' request cycles, with exec_done noise.
  task automatic do_fetch(input logic [31:0] word, input int delay);
    r_wait = 0; r_req = 0; r_tmo = 1'b0; r_stable = 1'b1; r_addr = 32'hx;
    while (imem_req !== 1'b1 && r_wait < 20) begin step; r_wait++; end
    if (imem_req !== 1'b1) begin
      r_tmo = 1'b1;
    end else begin
      r_addr = imem_addr;
      while (imem_req === 1'b1 && r_req < 50) begin
        if (imem_addr !== r_addr) r_stable = 1'b0;
        imem_ack  = (r_req == delay);
        imem_data = (r_req == delay) ? word : $urandom;
        exec_done = 1'($urandom_range(0, 1));
        step;
        r_req++;
      end
      if (r_req >= 50) r_tmo = 1'b1;
    end
    imem_ack = 1'b0; exec_done = 1'b0; imem_data = $urandom;
  endtask

  task automatic do_exec(input bit sc, input bit sj, input bit z, input bit en_after);
    SaltoCond = sc; Saltoincond = sj; Zero = z;
    exec_done = 1'b1; en = en_after;
    step;
    exec_done = 1'b0; SaltoCond = 1'b0; Saltoincond = 1'b0; Zero = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] word, input int delay, input int hold,
                           input bit sc, input bit sj, input bit z, input bit en_after);
    en = 1'b1;
    do_fetch(word, delay);
    repeat (hold) begin
      imem_ack = 1'($urandom_range(0, 1)); imem_data = $urandom;
      step;
    end
    imem_ack = 1'b0;
    if (!r_tmo) m_pc = model_next(m_pc, word, sc, sj, z);
    do_exec(sc, sj, z, en_after);
  endtask

  task automatic test_reset;
    do_reset;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", pc); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", instr); end
    vectors++; if (opcode !== OP_RTYPE) begin miscompares++; $display("FAIL reset_opcode: got %h want 0", opcode); end
    vectors++; if (pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); end
`ifdef FETCH_PERF_EN
    vectors++; if (instr_retired !== 32'h0) begin miscompares++; $display("FAIL reset_retired: got %0d want 0", instr_retired); end
`endif
  endtask

  task automatic test_first_fetch;
    logic [31:0] w;
    w = {OP_LW, 26'($urandom)};
    en = 1'b1;
    do_fetch(w, 0);
    vectors++; if (r_tmo) begin miscompares++; $display("FAIL first_timeout: got timeout want response"); end
    vectors++; if (r_addr !== 32'h0) begin miscompares++; $display("FAIL first_addr: got %h want 0", r_addr); end
    vectors++; if (r_wait + r_req != 2) begin miscompares++; $display("FAIL first_latency: got %0d want 2", r_wait + r_req); end
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid: got %b want 1", instr_valid); end
    vectors++; if (instr !== w) begin miscompares++; $display("FAIL first_instr: got %h want %h", instr, w); end
    vectors++; if (opcode !== OP_LW) begin miscompares++; $display("FAIL first_opcode: got %h want %h", opcode, OP_LW); end
    do_exec(1'b0, 1'b0, 1'b0, 1'b1);
    vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL first_next_pc: got %h want 4", pc); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL first_refetch: got req=%b addr=%h want req=1 addr=4", imem_req, imem_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL first_valid_drop: got %b want 0", instr_valid); end
  endtask

  task automatic test_ack_delay;
    logic [31:0] w;
    w = {OP_SW, 26'($urandom)};
    en = 1'b0;
    do_fetch(w, 3);
    vectors++; if (r_req != 4 || r_tmo) begin miscompares++; $display("FAIL delay_req_cycles: got %0d want 4", r_req); end
    vectors++; if (!r_stable || r_addr !== 32'h4) begin miscompares++; $display("FAIL delay_addr: got %h stable=%b want 4 stable=1", r_addr, r_stable); end
    vectors++; if (instr !== w) begin miscompares++; $display("FAIL delay_instr: got %h want %h", instr, w); end
    imem_ack = 1'b1; imem_data = ~w;
    step;
    imem_ack = 1'b0;
    vectors++; if (instr !== w || instr_valid !== 1'b1) begin miscompares++; $display("FAIL stray_ack_issue: got %h valid=%b want %h valid=1", instr, instr_valid, w); end
    do_exec(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++; if (pc !== 32'h8 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL to_idle: got pc=%h req=%b valid=%b want pc=8 req=0 valid=0", pc, imem_req, instr_valid); end
    exec_done = 1'b1;
    step;
    exec_done = 1'b0;
    vectors++; if (pc !== 32'h8 || imem_req !== 1'b0) begin miscompares++; $display("FAIL idle_exec_done: got pc=%h req=%b want pc=8 req=0", pc, imem_req); end
    m_pc = 32'h8;
  endtask

  task automatic test_branch;
    run_instr(enc_j(26'h40), 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL br_setup_jump: got %h want 100", pc); end
    run_instr(enc_beq(16'hFFFE), 1, 1, 1'b1, 1'b0, 1'b1, 1'b1);
    vectors++; if (pc !== 32'hFC) begin miscompares++; $display("FAIL beq_taken: got %h want fc", pc); end
    run_instr(enc_j(26'h40), 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_instr(enc_beq(16'hFFFE), 0, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++; if (pc !== 32'h104) begin miscompares++; $display("FAIL beq_not_taken: got %h want 104", pc); end
  endtask

  task automatic test_jump_priority;
    run_instr(enc_j(26'h3FF_FFFF), 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_instr({OP_RTYPE, 26'h0}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++; if (pc !== 32'h1000_0000) begin miscompares++; $display("FAIL jp_setup: got %h want 10000000", pc); end
    run_instr(enc_j(26'h40), 2, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    vectors++; if (pc !== 32'h1000_0100) begin miscompares++; $display("FAIL jump_wins: got %h want 10000100", pc); end
  endtask

  task automatic test_wrap;
    do_reset;
    run_instr(enc_beq(16'hFFFE), 0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    vectors++; if (pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL backward_wrap: got %h want fffffffc", pc); end
    vectors++; if (pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL pc_plus4_wrap: got %h want 0", pc_plus4); end
    run_instr({OP_RTYPE, 26'h0}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL seq_wrap: got %h want 0", pc); end
  endtask

  task automatic test_reset_mid_fetch;
    run_instr(enc_j(26'h80), 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL mid_setup: got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr); end
    reset_n = 1'b0; en = 1'b0;
    step;
    vectors++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got req=%b pc=%h valid=%b want req=0 pc=0 valid=0", imem_req, pc, instr_valid); end
    reset_n = 1'b1; imem_ack = 1'b1; imem_data = $urandom;
    step;
    imem_ack = 1'b0;
    vectors++; if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL late_ack: got instr=%h valid=%b req=%b want 0/0/0", instr, instr_valid, imem_req); end
    m_pc = 32'h0;
  endtask

  task automatic test_random;
    logic [31:0] w, exp_addr;
    bit          sc, sj, z;
    int          kind;
    do_reset;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      w = $urandom; sc = 1'b0; sj = 1'b0; z = 1'($urandom_range(0, 1));
      case (kind)
        0: sc = 1'($urandom_range(0, 1)) & ~z;
        1: begin w[31:26] = OP_BEQ; sc = 1'b1; end
        default: begin w[31:26] = OP_J; sj = 1'b1; sc = 1'($urandom_range(0, 1)); end
      endcase
      exp_addr = m_pc;
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), sc, sj, z, ($urandom_range(0, 3) != 0));
      vectors++; if (r_tmo || r_addr !== exp_addr) begin miscompares++; $display("FAIL rnd_addr[%0d]: got %h tmo=%b want %h", i, r_addr, r_tmo, exp_addr); end
      vectors++; if (instr !== w || opcode !== w[31:26]) begin miscompares++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, instr, w); end
      vectors++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h/%h want %h", i, pc, pc_plus4, m_pc); end
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf;
    do_reset;
    for (int i = 0; i < 5; i++) run_instr({OP_RTYPE, 26'($urandom)}, i % 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++; if (instr_retired !== 32'd5) begin miscompares++; $display("FAIL perf_count: got %0d want 5", instr_retired); end
    do_reset;
    vectors++; if (instr_retired !== 32'd0) begin miscompares++; $display("FAIL perf_reset: got %0d want 0", instr_retired); end
  endtask
`endif

  initial begin
    test_reset;
    test_first_fetch;
    test_ack_delay;
    test_branch;
    test_jump_priority;
    test_wrap;
    test_reset_mid_fetch;
    test_random;
`ifdef FETCH_PERF_EN
    test_perf;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
